// File: rtl/axis_to_strobe_iq.sv
// axis_to_strobe_iq
// Rate-pacing front end for the IQ CIC interpolator. Packed IQ samples arrive
// on AXI-Stream and are held in a 2-entry FIFO. One sample leaves per output
// strobe, and strobes are spaced every `rate` clocks. Bursts are delimited by
// tlast. A strobe that finds the FIFO empty in the middle of a burst reports
// an underflow.
//
// Ports:
//   clk, reset       clock, synchronous active-high reset
//   rate_stb, rate   load a new strobe period (clamped to 1..MAX_RATE) and
//                    restart the cadence
//   enable           strobe generation enable (the counter holds when low)
//   s_axis_*         sample input, tdata = {I, Q}
//   strobe_out       one-cycle strobe to the interpolator
//   out_itdata/out_qtdata  sample carried by strobe_out (zero otherwise)
//   underflow        pulse: a strobe found no data while in a burst
//   underflow_count  saturating count of underflow pulses
//   eob              pulse: coincides with the strobe of the tlast sample
module axis_to_strobe_iq #(
  parameter int DATA_WIDTH = 16,
  parameter int MAX_RATE   = 128,
  parameter int CNT_WIDTH  = 16,
  localparam int RW        = $clog2(MAX_RATE + 1)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    rate_stb,
  input  logic [RW-1:0]           rate,
  input  logic                    enable,
  input  logic [2*DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  input  logic                    s_axis_tlast,
  output logic                    strobe_out,
  output logic [DATA_WIDTH-1:0]   out_itdata,
  output logic [DATA_WIDTH-1:0]   out_qtdata,
  output logic                    underflow,
  output logic [CNT_WIDTH-1:0]    underflow_count,
  output logic                    eob
);

  // FIFO entry: {tlast, I, Q}
  localparam int EW = 2*DATA_WIDTH + 1;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t          state_r;
  logic [RW-1:0]   rate_r;
  logic [RW-1:0]   cnt_r;
  logic            tick_s;

  logic [EW-1:0]   mem_r [2];
  logic            wr_ptr_r;
  logic            rd_ptr_r;
  logic [1:0]      count_r;
  logic [1:0]      count_next_s;
  logic            push_s;
  logic            pop_s;
  logic [EW-1:0]   head_s;

  // Period 0 would never tick, so it is treated as 1; oversize values saturate.
  function automatic logic [RW-1:0] clamp_rate(input logic [RW-1:0] r);
    logic [RW-1:0] res;
    if (r == {RW{1'b0}}) begin
      res = RW'(1);
    end else if (r > RW'(MAX_RATE)) begin
      res = RW'(MAX_RATE);
    end else begin
      res = r;
    end
    return res;
  endfunction

  // Tick on the last count of a period; a rate_stb cycle never ticks.
  always_comb begin
    tick_s = 1'b0;
    if (enable && !rate_stb && (cnt_r == rate_r - RW'(1))) begin
      tick_s = 1'b1;
    end else begin
      tick_s = 1'b0;
    end
  end

  // FIFO handshake and occupancy bookkeeping.
  always_comb begin
    push_s       = s_axis_tvalid && s_axis_tready;
    // Only entries present before this cycle may leave, so a push into an
    // empty FIFO cannot be popped in the same cycle.
    pop_s        = tick_s && (count_r != 2'd0);
    count_next_s = count_r;
    case ({push_s, pop_s})
      2'b10:   count_next_s = count_r + 2'd1;
      2'b01:   count_next_s = count_r - 2'd1;
      default: count_next_s = count_r;
    endcase
  end

  assign head_s = mem_r[rd_ptr_r];

  // Rate latch and strobe period counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      rate_r <= RW'(MAX_RATE);
      cnt_r  <= {RW{1'b0}};
    end else if (rate_stb) begin
      rate_r <= clamp_rate(rate);
      cnt_r  <= {RW{1'b0}};
    end else if (enable) begin
      if (tick_s) begin
        cnt_r <= {RW{1'b0}};
      end else begin
        cnt_r <= cnt_r + RW'(1);
      end
    end
  end

  // FIFO storage; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= {s_axis_tlast, s_axis_tdata};
    end
  end

  // FIFO pointers, occupancy and registered tready.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r      <= 1'b0;
      rd_ptr_r      <= 1'b0;
      count_r       <= 2'd0;
      s_axis_tready <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= ~wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      count_r       <= count_next_s;
      s_axis_tready <= (count_next_s != 2'd2);
    end
  end

  // Burst state machine with registered strobe, data and status outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r         <= ST_IDLE;
      strobe_out      <= 1'b0;
      out_itdata      <= {DATA_WIDTH{1'b0}};
      out_qtdata      <= {DATA_WIDTH{1'b0}};
      underflow       <= 1'b0;
      underflow_count <= {CNT_WIDTH{1'b0}};
      eob             <= 1'b0;
    end else begin
      // Data is zero on every cycle that does not carry a sample.
      strobe_out <= tick_s;
      out_itdata <= {DATA_WIDTH{1'b0}};
      out_qtdata <= {DATA_WIDTH{1'b0}};
      underflow  <= 1'b0;
      eob        <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          // An empty tick in IDLE is just a zero strobe, not an underflow.
          if (pop_s) begin
            out_itdata <= head_s[2*DATA_WIDTH-1:DATA_WIDTH];
            out_qtdata <= head_s[DATA_WIDTH-1:0];
            if (head_s[EW-1]) begin
              eob     <= 1'b1;
              state_r <= ST_IDLE;
            end else begin
              state_r <= ST_RUN;
            end
          end
        end
        ST_RUN: begin
          if (pop_s) begin
            out_itdata <= head_s[2*DATA_WIDTH-1:DATA_WIDTH];
            out_qtdata <= head_s[DATA_WIDTH-1:0];
            if (head_s[EW-1]) begin
              eob     <= 1'b1;
              state_r <= ST_IDLE;
            end
          end else if (tick_s) begin
            underflow <= 1'b1;
            if (underflow_count != {CNT_WIDTH{1'b1}}) begin
              underflow_count <= underflow_count + CNT_WIDTH'(1);
            end
          end
        end
        default: state_r <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axis_to_strobe_iq.sv
// Scoreboard bench for axis_to_strobe_iq: stimulus pushes the expected strobe
// contents (and optional timing) into a queue; a monitor pops one entry per
// strobe_out and compares.
module tb_axis_to_strobe_iq;
  localparam int DW = 16;
  localparam int MR = 128;
  localparam int CW = 16;
  localparam int RW = $clog2(MR + 1);

  logic            clk = 1'b0;
  logic            reset;
  logic            rate_stb;
  logic [RW-1:0]   rate;
  logic            enable;
  logic [2*DW-1:0] tdata;
  logic            tvalid;
  logic            tready;
  logic            tlast;
  logic            strobe_out;
  logic [DW-1:0]   out_i;
  logic [DW-1:0]   out_q;
  logic            underflow;
  logic [CW-1:0]   ucount;
  logic            eob;

  axis_to_strobe_iq #(.DATA_WIDTH(DW), .MAX_RATE(MR), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .rate_stb(rate_stb), .rate(rate), .enable(enable),
    .s_axis_tdata(tdata), .s_axis_tvalid(tvalid), .s_axis_tready(tready),
    .s_axis_tlast(tlast), .strobe_out(strobe_out), .out_itdata(out_i),
    .out_qtdata(out_q), .underflow(underflow), .underflow_count(ucount), .eob(eob)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [DW-1:0] i;
    logic [DW-1:0] q;
    logic          e;
    logic          u;
    int            at;   // absolute cycle of the strobe, -1 = not checked
    int            gap;  // cycles since previous strobe, 0 = not checked
  } exp_t;

  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  int last_strobe = -1;

  // Monitor: one scoreboard entry per strobe.
  always @(negedge clk) begin
    exp_t x;
    if (strobe_out) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_strobe cyc=%0d i=%h q=%h eob=%b uf=%b", cyc, out_i, out_q, eob, underflow);
      end else begin
        x = sb.pop_front();
        checks++;
        if (out_i !== x.i || out_q !== x.q || eob !== x.e || underflow !== x.u) begin
          errors++;
          $display("FAIL strobe_data cyc=%0d got i=%h q=%h eob=%b uf=%b want i=%h q=%h eob=%b uf=%b",
                   cyc, out_i, out_q, eob, underflow, x.i, x.q, x.e, x.u);
        end
        if (x.at >= 0) begin
          checks++;
          if (cyc != x.at) begin
            errors++;
            $display("FAIL strobe_time got cyc=%0d want %0d", cyc, x.at);
          end
        end
        if (x.gap > 0) begin
          checks++;
          if (cyc - last_strobe != x.gap) begin
            errors++;
            $display("FAIL strobe_gap cyc=%0d got %0d want %0d", cyc, cyc - last_strobe, x.gap);
          end
        end
      end
      last_strobe = cyc;
    end else if (eob || underflow) begin
      checks++; errors++;
      $display("FAIL pulse_without_strobe cyc=%0d eob=%b uf=%b", cyc, eob, underflow);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic expect_s(input int i, input int q, input bit e, input bit u, input int at, input int gap);
    exp_t x;
    x.i = DW'(i); x.q = DW'(q); x.e = e; x.u = u; x.at = at; x.gap = gap;
    sb.push_back(x);
  endtask

  // Hold a sample on the bus until accepted; waited = cycles spent with tready low.
  task automatic push(input int i, input int q, input bit last, output int waited);
    bit acc;
    acc = 1'b0;
    waited = 0;
    tdata  = {DW'(i), DW'(q)};
    tlast  = last;
    tvalid = 1'b1;
    while (!acc && waited < 300) begin
      acc = tready;
      @(posedge clk);
      #1;
      if (!acc) waited++;
    end
    if (!acc) begin
      checks++; errors++;
      $display("FAIL push_timeout i=%0d q=%0d", i, q);
    end
    tvalid = 1'b0;
    tlast  = 1'b0;
  endtask

  task automatic wait_drain(input int max);
    int n;
    n = 0;
    while (sb.size() != 0 && n < max) begin
      @(posedge clk);
      #2;
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout got %0d pending want 0", sb.size());
      sb.delete();
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    int w;
    int r;
    reset = 1'b1; rate_stb = 1'b0; rate = '0; enable = 1'b0;
    tdata = '0; tvalid = 1'b0; tlast = 1'b0;
    step(); step();
    chk("reset_tready", 32'(tready), 32'd0);
    chk("reset_strobe", 32'(strobe_out), 32'd0);
    chk("reset_ucount", 32'(ucount), 32'd0);
    chk("reset_data", {out_i, out_q}, 32'd0);
    reset = 1'b0;
    step();
    chk("tready_after_reset", 32'(tready), 32'd1);

    // 3-sample burst at rate 4, then idle zero strobes with no underflow
    r = cyc;
    rate_stb = 1'b1; rate = RW'(4); enable = 1'b1;
    expect_s(1, -1, 1'b0, 1'b0, r + 5, 0);
    expect_s(2, -2, 1'b0, 1'b0, -1, 4);
    expect_s(3, -3, 1'b1, 1'b0, -1, 4);
    expect_s(0, 0, 1'b0, 1'b0, -1, 4);
    expect_s(0, 0, 1'b0, 1'b0, -1, 4);
    step();
    rate_stb = 1'b0;
    push(1, -1, 1'b0, w);
    push(2, -2, 1'b0, w);
    push(3, -3, 1'b1, w);
    wait_drain(100);
    enable = 1'b0;

    // underflow: one sample, three empty strobes mid-burst, then a late sample
    r = cyc;
    rate_stb = 1'b1; rate = RW'(4); enable = 1'b1;
    expect_s(5, -5, 1'b0, 1'b0, r + 5, 0);
    expect_s(0, 0, 1'b0, 1'b1, -1, 4);
    expect_s(0, 0, 1'b0, 1'b1, -1, 4);
    expect_s(0, 0, 1'b0, 1'b1, -1, 4);
    step();
    rate_stb = 1'b0;
    push(5, -5, 1'b0, w);
    wait_drain(100);
    chk("ucount_after_3_uf", 32'(ucount), 32'd3);
    expect_s(6, -6, 1'b1, 1'b0, -1, 4);
    push(6, -6, 1'b1, w);
    wait_drain(100);
    chk("ucount_hold", 32'(ucount), 32'd3);
    enable = 1'b0;

    // rate 1, 10-sample back-to-back burst
    rate_stb = 1'b1; rate = RW'(1); enable = 1'b0;
    step();
    rate_stb = 1'b0;
    for (int k = 0; k < 10; k++) expect_s(k + 1, -(k + 1), (k == 9), 1'b0, -1, (k > 0) ? 1 : 0);
    push(1, -1, 1'b0, w);
    chk("burst_tready_0", 32'(w), 32'd0);
    enable = 1'b1;
    for (int k = 1; k < 10; k++) begin
      push(k + 1, -(k + 1), (k == 9), w);
      chk("burst_tready", 32'(w), 32'd0);
    end
    step();
    enable = 1'b0;
    wait_drain(20);

    // enable low: FIFO fills, tready drops, no strobes; enable releases in order
    rate_stb = 1'b1; rate = RW'(2); enable = 1'b0;
    step();
    rate_stb = 1'b0;
    push(7, -7, 1'b0, w);
    push(8, -8, 1'b0, w);
    chk("tready_full", 32'(tready), 32'd0);
    tdata = {DW'(9), DW'(-9)}; tlast = 1'b1; tvalid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk("tready_held_low", 32'(tready), 32'd0);
    end
    expect_s(7, -7, 1'b0, 1'b0, -1, 0);
    expect_s(8, -8, 1'b0, 1'b0, -1, 2);
    expect_s(9, -9, 1'b1, 1'b0, -1, 2);
    enable = 1'b1;
    push(9, -9, 1'b1, w);
    wait_drain(50);
    enable = 1'b0;

    // rate 0 clamps to 1
    r = cyc;
    rate_stb = 1'b1; rate = RW'(0); enable = 1'b1;
    expect_s(0, 0, 1'b0, 1'b0, r + 2, 0);
    expect_s(0, 0, 1'b0, 1'b0, r + 3, 0);
    expect_s(0, 0, 1'b0, 1'b0, r + 4, 0);
    step();
    rate_stb = 1'b0;
    step(); step(); step();
    enable = 1'b0;
    wait_drain(10);

    // rate 200 clamps to 128
    r = cyc;
    rate_stb = 1'b1; rate = RW'(200); enable = 1'b1;
    expect_s(0, 0, 1'b0, 1'b0, r + 129, 0);
    expect_s(0, 0, 1'b0, 1'b0, -1, 128);
    step();
    rate_stb = 1'b0;
    wait_drain(400);
    enable = 1'b0;

    // reset mid-burst with 2 samples buffered
    rate_stb = 1'b1; rate = RW'(2); enable = 1'b0;
    step();
    rate_stb = 1'b0;
    push(10, -10, 1'b0, w);
    expect_s(10, -10, 1'b0, 1'b0, -1, 0);
    enable = 1'b1;
    wait_drain(20);
    enable = 1'b0;
    push(11, -11, 1'b0, w);
    push(12, -12, 1'b0, w);
    chk("tready_full_prereset", 32'(tready), 32'd0);
    reset = 1'b1;
    step();
    chk("mid_reset_tready", 32'(tready), 32'd0);
    chk("mid_reset_ucount", 32'(ucount), 32'd0);
    reset = 1'b0;
    step();
    chk("post_reset_tready", 32'(tready), 32'd1);
    chk("post_reset_ucount", 32'(ucount), 32'd0);
    r = cyc;
    enable = 1'b1;
    expect_s(0, 0, 1'b0, 1'b0, r + 128, 0);
    wait_drain(200);
    enable = 1'b0;

    for (int k = 0; k < 5; k++) step();
    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/axis_to_strobe_iq.md
Name: axis_to_strobe_iq

Overview:
- Rate-pacing front end for the IQ CIC interpolator.
- Accepts packed IQ samples on AXI-Stream and buffers them in a 2-entry FIFO.
- Emits one sample per output strobe, with strobes spaced every `rate` clocks, driving the interpolator's strobe_in/in_itdata/in_qtdata.
- Handles burst start/end via tlast and reports underflow when a strobe finds no data mid-burst.

Parameters:
DATA_WIDTH, 16, width of each of I and Q
MAX_RATE, 128, largest supported strobe period in clocks
CNT_WIDTH, 16, width of the saturating underflow counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
rate_stb  input  1  load `rate` and restart strobe counter
rate  input  $clog2(MAX_RATE+1)  strobe period in clocks
enable  input  1  strobe generation enable
s_axis_tdata  input  2*DATA_WIDTH  {I[2W-1:W], Q[W-1:0]}
s_axis_tvalid  input  1  sample valid
s_axis_tready  output  1  FIFO can accept
s_axis_tlast  input  1  last sample of burst
strobe_out  output  1  one-cycle sample strobe to interpolator
out_itdata  output  DATA_WIDTH  I sample, valid with strobe_out
out_qtdata  output  DATA_WIDTH  Q sample, valid with strobe_out
underflow  output  1  one-cycle pulse, strobe with empty FIFO in RUN
underflow_count  output  CNT_WIDTH  saturating count of underflow pulses
eob  output  1  one-cycle pulse, coincident with strobe_out of tlast sample

Behaviour:
- Reset: all outputs 0 (s_axis_tready 0 during reset, 1 the cycle after). FIFO empty, state IDLE, counter 0, latched rate = MAX_RATE.
- Rate latch:
  - On rate_stb, rate_r <= clamp(rate, 1, MAX_RATE), where rate 0 is treated as 1.
  - Also on rate_stb, cnt <= 0, and no strobe is issued that cycle.
- Strobe counter:
  - When enable=1 and no rate_stb: cnt increments; at cnt == rate_r-1, tick=1 and cnt <= 0.
  - rate_r=1 gives tick every cycle.
  - enable=0 holds cnt and produces no tick.
- Output latency: strobe_out, data, eob and underflow are registered and assert the cycle after tick. strobe_out period = rate_r clocks exactly.
- FIFO (depth 2):
  - s_axis_tready = (count < 2).
  - Push on tvalid & tready; pop on tick when nonempty.
  - Simultaneous push and pop leaves count unchanged and preserves order.
  - A push into an empty FIFO is not poppable in the same cycle; it becomes eligible the next cycle.
- States:
  - IDLE:
    - On tick with FIFO empty, output a strobe with I=Q=0, no underflow.
    - On tick with FIFO nonempty, pop, output the sample, and go to RUN; a tlast on that sample returns to IDLE with eob.
  - RUN:
    - On tick with FIFO nonempty, pop and output.
    - If the popped sample had tlast, pulse eob and go to IDLE.
    - On tick with FIFO empty, output I=Q=0, pulse underflow, increment underflow_count (saturating at all-ones), and stay in RUN.
- Zero output: out_itdata/out_qtdata return to 0 on cycles without strobe_out. Non-strobe cycles have no meaning to the consumer.
- rate_stb mid-burst: state and FIFO contents are preserved; only the cadence restarts.
- Reset mid-burst: FIFO is flushed, state IDLE, underflow_count cleared.

Test Plan:
- rate=4, enable=1, push 3 samples (I,Q) = (1,-1),(2,-2),(3,-3), tlast on 3rd, before first tick -> strobes every 4 clocks carry the three samples in order; eob with the 3rd; subsequent strobes carry 0 with no underflow.
- rate=4, push sample A (no tlast), then withhold data for 3 strobe periods -> strobe after A carries 0, underflow pulses 3 times, underflow_count=3; next pushed sample is output on the following strobe.
- rate=1, continuous tvalid with 10-sample burst -> strobe_out high 10 consecutive cycles with no gaps; tready stays 1; eob on the 10th sample.
- tvalid held high while enable=0 -> tready drops after 2 accepts; no strobes; enable=1 releases samples in order.
- rate_stb with rate=0, then rate=200 (MAX_RATE=128) -> strobe periods of 1 and 128 clocks respectively; first strobe after each rate_stb comes rate_r+1 cycles after the rate_stb cycle (tick at cnt==rate_r-1 plus one register stage).
- Assert reset mid-burst with 2 samples buffered -> next cycle tready=1, underflow_count=0; first post-reset strobe carries 0 in IDLE.
